ebi_master: RTL and testbench
=============================

Name: ebi_master

Overview:
- Initiator side of the MCU↔FPGA external bus interface (EBI); generates the same active-low cs/rd/wr, 19-bit address and 16-bit data cycles that the on-chip ebi responder decodes.
- Used as a soft-MCU bus driver for hardware-in-loop self-test and for driving a second Mecobo board's EBI port.
- Converts a valid/ready request into one timed EBI read or write cycle.
- Returns a one-cycle response with the read data.

Parameters:
- SETUP_CYCLES, 2: cycles cs and addr are asserted before the strobe; legal range 1..15.
- STROBE_CYCLES, 4: cycles rd or wr is held low; legal range 1..15.
- HOLD_CYCLES, 2: cycles cs, addr and write data are held after the strobe; legal range 1..15.
- TIMEOUT_CYCLES, 64: maximum strobe extension while waiting for ready (used only with EBI_ARDY_EN).

Ports:
- clk  input  1  system clock (sys_clk domain, 100 MHz)
- rst  input  1  reset; synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  19  word address
- req_wdata  input  16  write data
- rsp_valid  output  1  one-cycle pulse when a cycle completes
- rsp_rdata  output  16  read data (0 for writes)
- rsp_err  output  1  timeout flag, valid with rsp_valid
- ebi_addr  output  19  bus address
- ebi_data_out  output  16  bus write data
- ebi_data_oe  output  1  tristate enable for ebi_data_out
- ebi_data_in  input  16  bus read data
- ebi_cs  output  1  chip select, active-low
- ebi_rd  output  1  read strobe, active-low
- ebi_wr  output  1  write strobe, active-low
- ebi_ardy  input  1  target ready, active-high (present only with EBI_ARDY_EN)

Behaviour:
- All outputs are registered.
- Reset values (rst low at a clk edge):
  - ebi_cs = ebi_rd = ebi_wr = 1.
  - ebi_addr = 0, ebi_data_out = 0, ebi_data_oe = 0.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - State = IDLE.
- State machine:
  - IDLE: req_ready = 1, ebi_cs = 1. On req_valid & req_ready, latch wr/addr/wdata and go to SETUP.
  - SETUP: ebi_cs = 0, ebi_addr = latched address; ebi_data_oe = 1 and data driven for writes. Lasts SETUP_CYCLES cycles, then STROBE.
  - STROBE: ebi_rd = 0 (read) or ebi_wr = 0 (write). Lasts STROBE_CYCLES cycles. For reads, ebi_data_in is captured at the clk edge ending the last STROBE cycle.
  - HOLD: strobes = 1; cs, addr, data and oe unchanged. Lasts HOLD_CYCLES cycles, then IDLE with rsp_valid = 1 for exactly one cycle.
- Timing: if the request is accepted in cycle 0, SETUP occupies cycles 1..S, STROBE S+1..S+T, HOLD S+T+1..S+T+H, and rsp_valid is high in cycle S+T+H+1.
- req_ready is 0 from SETUP through HOLD.
- Back-to-back: a request may be accepted in the same cycle rsp_valid is high. ebi_cs is therefore high for at least one cycle between transactions.
- rd and wr are never both low. A strobe is never low while cs is high.
- rsp_rdata holds its value until the next response. Writes set rsp_rdata = 0.
- req_* inputs are ignored outside IDLE. Latched values are immune to input changes mid-cycle.
- rst low mid-transaction: at the next edge, strobes and cs go high, oe goes 0, and the state returns to IDLE. No rsp_valid is generated for the aborted cycle. req_ready returns to 1 in the first cycle after rst is released.

Optional Feature:
- Macro: EBI_ARDY_EN.
- Defined:
  - ebi_ardy port exists.
  - After STROBE_CYCLES cycles, STROBE is extended while ebi_ardy = 0.
  - Read data is captured on the edge where ardy = 1 and the minimum strobe has elapsed.
  - If TIMEOUT_CYCLES extension cycles pass with ardy still 0, the block proceeds to HOLD, sets rsp_err = 1 with the response, and sets rsp_rdata = 16'hDEAD.
- Undefined:
  - No ebi_ardy port; fixed timing.
  - rsp_err is constant 0.

Decomposition:
- Shared package mecobo_ebi_pkg:
  - EBI_ADDR_W = 19, EBI_DATA_W = 16.
  - State encoding: IDLE, SETUP, STROBE, HOLD.
  - Error data constant 16'hDEAD.
- One sub-module, ebi_phase_timer:
  - Loadable 4-bit down-counter with a done flag.
  - Reused for each phase; with EBI_ARDY_EN, a second instance (wider) serves as the timeout counter.

Test Plan:
- Write, S/T/H = 2/4/2, addr 0x00012, data 0xBEEF, accepted in cycle 0:
  - cs low in cycles 1..8, wr low in cycles 3..6, oe high in cycles 1..8.
  - rsp_valid in cycle 9 with rsp_rdata = 0.
- Read, addr 0x7FFFF, bench drives ebi_data_in = 0x1234 in cycles 5..6 and 0xFFFF otherwise:
  - rd low in cycles 3..6, oe stays 0.
  - rsp_valid in cycle 9 with rsp_rdata = 0x1234.
- Back-to-back: req_valid held high for 3 requests:
  - Acceptances at cycles 0, 9, 18.
  - cs high exactly in cycles 9 and 18; exactly 3 rsp_valid pulses.
- Reset during STROBE (rst low in cycle 4):
  - Cycle 5: cs = rd = wr = 1, oe = 0.
  - No rsp_valid.
  - After release, req_ready = 1 and a fresh read completes normally.
- Random req_valid/req_wr for 10k cycles: assertions hold throughout.
  - Never rd & wr both low; never a strobe low with cs high.
  - Response count equals acceptance count.
- EBI_ARDY_EN, TIMEOUT_CYCLES = 8:
  - ardy low for 3 extra cycles: rsp_valid delayed by 3, rsp_err = 0.
  - ardy held low: rsp_err = 1, rsp_rdata = 0xDEAD.

Source files
------------

// File: rtl/mecobo_ebi_pkg.sv
// mecobo_ebi_pkg: shared widths, FSM states and constants for the EBI master.
// Dependents honour the optional EBI_ARDY_EN feature macro.
package mecobo_ebi_pkg;

    localparam int EBI_ADDR_W = 19;
    localparam int EBI_DATA_W = 16;

    // Returned as read data when the target never signals ready.
    localparam logic [EBI_DATA_W-1:0] EBI_ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } ebi_state_e;

    // Phase timers count down to zero, so a phase of n cycles loads n-1.
    function automatic logic [3:0] phase_ld(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/ebi_master_if.sv
// ebi_master_if: request/response handshake plus the EBI pin bundle.
// The ebi_ardy pin exists only when EBI_ARDY_EN is defined.
interface ebi_master_if;
    import mecobo_ebi_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [EBI_ADDR_W-1:0] req_addr;
    logic [EBI_DATA_W-1:0] req_wdata;

    logic                  rsp_valid;
    logic [EBI_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [EBI_ADDR_W-1:0] ebi_addr;
    logic [EBI_DATA_W-1:0] ebi_data_out;
    logic                  ebi_data_oe;
    logic [EBI_DATA_W-1:0] ebi_data_in;
    logic                  ebi_cs;
    logic                  ebi_rd;
    logic                  ebi_wr;
`ifdef EBI_ARDY_EN
    logic                  ebi_ardy;
`endif

    modport master (
`ifdef EBI_ARDY_EN
        input  ebi_ardy,
`endif
        input  req_valid, req_wr, req_addr, req_wdata, ebi_data_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ebi_addr, ebi_data_out, ebi_data_oe,
        output ebi_cs, ebi_rd, ebi_wr
    );

    modport slave (
`ifdef EBI_ARDY_EN
        output ebi_ardy,
`endif
        output req_valid, req_wr, req_addr, req_wdata, ebi_data_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ebi_addr, ebi_data_out, ebi_data_oe,
        input  ebi_cs, ebi_rd, ebi_wr
    );

endinterface

// File: rtl/ebi_phase_timer.sv
// ebi_phase_timer: loadable down-counter that parks at zero.
// done is high while the count is zero, i.e. in the last cycle of a phase.
module ebi_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Load wins over counting; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/ebi_master.sv
// ebi_master: turns one valid/ready request into a timed EBI read/write cycle.
// EBI_ARDY_EN: strobe stretched while ebi_ardy is low, bounded by TIMEOUT_CYCLES.
module ebi_master
    import mecobo_ebi_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          rst,
    ebi_master_if.master bus
);

    localparam logic [3:0] SETUP_LD  = phase_ld(SETUP_CYCLES);
    localparam logic [3:0] STROBE_LD = phase_ld(STROBE_CYCLES);
    localparam logic [3:0] HOLD_LD   = phase_ld(HOLD_CYCLES);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
        STROBE_CYCLES < 1 || STROBE_CYCLES > 15 ||
        HOLD_CYCLES < 1 || HOLD_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("ebi_master: timing parameter out of range");
    end

    ebi_state_e            st_q;
    ebi_state_e            st_d;
    logic                  accept;
    logic                  wr_q;
    logic                  wr_n;
    logic [EBI_DATA_W-1:0] rdata_q;
    logic                  ph_load;
    logic [3:0]            ph_val;
    logic                  ph_done;
    logic                  go_hold;
    logic                  cap;
    logic                  fin;
`ifdef EBI_ARDY_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic                  tmo_load;
    logic                  tmo_en;
    logic                  tmo_done;
    logic                  tmo_hit;
    logic                  err_q;
`endif

    assign accept = (st_q == IDLE) && bus.req_valid && bus.req_ready;
    assign wr_n   = accept ? bus.req_wr : wr_q;

    ebi_phase_timer #(.W(4)) u_phase (
        .clk  (clk),
        .rst  (rst),
        .load (ph_load),
        .en   (1'b1),
        .val  (ph_val),
        .done (ph_done)
    );

`ifdef EBI_ARDY_EN
    ebi_phase_timer #(.W(TMO_W)) u_tmo (
        .clk  (clk),
        .rst  (rst),
        .load (tmo_load),
        .en   (tmo_en),
        .val  (TMO_W'(TIMEOUT_CYCLES)),
        .done (tmo_done)
    );
`endif

    // Next-state decode and phase-timer reloads.
    always_comb begin
        st_d    = st_q;
        ph_load = 1'b0;
        ph_val  = '0;
        go_hold = 1'b0;
        cap     = 1'b0;
        fin     = 1'b0;
`ifdef EBI_ARDY_EN
        tmo_load = 1'b0;
        tmo_en   = 1'b0;
        tmo_hit  = 1'b0;
`endif
        unique case (st_q)
            IDLE: begin
                if (accept) begin
                    st_d    = SETUP;
                    ph_load = 1'b1;
                    ph_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (ph_done) begin
                    st_d    = STROBE;
                    ph_load = 1'b1;
                    ph_val  = STROBE_LD;
`ifdef EBI_ARDY_EN
                    tmo_load = 1'b1;
`endif
                end
            end
            STROBE: begin
                if (ph_done) begin
`ifdef EBI_ARDY_EN
                    if (bus.ebi_ardy) begin
                        cap     = 1'b1;
                        go_hold = 1'b1;
                    end else if (tmo_done) begin
                        tmo_hit = 1'b1;
                        go_hold = 1'b1;
                    end else begin
                        tmo_en = 1'b1;
                    end
`else
                    cap     = 1'b1;
                    go_hold = 1'b1;
`endif
                end
            end
            HOLD: begin
                if (ph_done) begin
                    st_d = IDLE;
                    fin  = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
        if (go_hold) begin
            st_d    = HOLD;
            ph_load = 1'b1;
            ph_val  = HOLD_LD;
        end
    end

    // State, request direction and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q    <= IDLE;
            wr_q    <= 1'b0;
            rdata_q <= '0;
`ifdef EBI_ARDY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            st_q <= st_d;
            if (accept) begin
                wr_q <= bus.req_wr;
            end
            if (cap) begin
                rdata_q <= bus.ebi_data_in;
            end
`ifdef EBI_ARDY_EN
            if (accept) begin
                err_q <= 1'b0;
            end
            if (tmo_hit) begin
                err_q   <= 1'b1;
                rdata_q <= EBI_ERR_DATA;
            end
`endif
        end
    end

    // Registered pins and handshake, all derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.req_ready    <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_err      <= 1'b0;
            bus.ebi_addr     <= '0;
            bus.ebi_data_out <= '0;
            bus.ebi_data_oe  <= 1'b0;
            bus.ebi_cs       <= 1'b1;
            bus.ebi_rd       <= 1'b1;
            bus.ebi_wr       <= 1'b1;
        end else begin
            bus.req_ready   <= (st_d == IDLE);
            bus.ebi_cs      <= (st_d == IDLE);
            bus.ebi_rd      <= !((st_d == STROBE) && !wr_q);
            bus.ebi_wr      <= !((st_d == STROBE) && wr_q);
            bus.ebi_data_oe <= (st_d != IDLE) && wr_n;
            if (accept) begin
                bus.ebi_addr <= bus.req_addr;
                if (bus.req_wr) begin
                    bus.ebi_data_out <= bus.req_wdata;
                end
            end
            bus.rsp_valid <= fin;
`ifdef EBI_ARDY_EN
            if (fin) begin
                bus.rsp_rdata <= (wr_q && !err_q) ? '0 : rdata_q;
                bus.rsp_err   <= err_q;
            end
`else
            if (fin) begin
                bus.rsp_rdata <= wr_q ? '0 : rdata_q;
            end
            bus.rsp_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ebi_master.sv
// tb_ebi_master: scoreboard bench for ebi_master with a cycle-exact bus model.
// Define EBI_ARDY_EN on both RTL and bench to cover ready stretching/timeout.
module tb_ebi_master;
    import mecobo_ebi_pkg::*;

    localparam int S   = 2;
    localparam int T   = 4;
    localparam int H   = 2;
    localparam int TMO = 8;
    localparam int LAT = S + T + H + 1;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;

    ebi_master_if bus ();

    ebi_master #(
        .SETUP_CYCLES   (S),
        .STROBE_CYCLES  (T),
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk (sys_clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          act = 1'b0;
    int          acc_a = -100;
    logic        acc_wr = 1'b0;
    logic [18:0] acc_addr = '0;
    logic [15:0] acc_wd = '0;
    bit          rst_prev_low = 1'b1;
    int          n_acc = 0;
    int          n_rsp = 0;
    int          ardy_mode = 0;
    exp_t        sb[$];
    int          acc_log[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] rd_pat(input logic [18:0] a);
        return (a == 19'h7FFFF) ? 16'h1234 : (a[15:0] ^ 16'hA5C3);
    endfunction

    function automatic int ext_cycles();
        return (ardy_mode == 1) ? 3 : (ardy_mode == 2) ? TMO : 0;
    endfunction

    // Target model: read data valid only late in the strobe, 0xFFFF otherwise.
    always @(posedge sys_clk) begin
        int k;
        cyc = cyc + 1;
        #1;
        k = cyc - acc_a;
        bus.ebi_data_in = (act && !acc_wr && k >= 5 + ext_cycles() &&
                           k <= 6 + ext_cycles()) ? rd_pat(acc_addr) : 16'hFFFF;
`ifdef EBI_ARDY_EN
        if (ardy_mode == 2) bus.ebi_ardy = 1'b0;
        else if (ardy_mode == 1) bus.ebi_ardy = !(act && k >= 3 && k <= 8);
        else bus.ebi_ardy = 1'b1;
`endif
    end

    // Monitor: per-cycle bus shape, strobe invariants and response scoreboard.
    always @(negedge sys_clk) begin
        int k;
        bit busy;
        bit strb;
        logic [5:0] want;
        logic [5:0] got;
        exp_t e;
        if (mon_en) begin
            k    = cyc - acc_a;
            busy = act && k >= 1 && k <= LAT - 1;
            strb = busy && k >= S + 1 && k <= S + T;
            got  = {bus.ebi_cs, bus.ebi_rd, bus.ebi_wr, bus.ebi_data_oe,
                    bus.rsp_valid, bus.req_ready};
            if (ardy_mode == 0) begin
                want = {!busy, !(strb && !acc_wr), !(strb && acc_wr),
                        busy && acc_wr, act && k == LAT,
                        !rst_prev_low && !busy};
                chk("shape", 32'(got), 32'(want));
                if (busy) chk("addr", 32'(bus.ebi_addr), 32'(acc_addr));
                if (busy && acc_wr) chk("wdata", 32'(bus.ebi_data_out), 32'(acc_wd));
            end
            chk("strobe_rule",
                32'({!bus.ebi_rd && !bus.ebi_wr,
                     bus.ebi_cs && (!bus.ebi_rd || !bus.ebi_wr)}), 32'd0);
            if (bus.rsp_valid) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    chk("rsp_spurious", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                    chk("err", 32'(bus.rsp_err), 32'(e.err));
                    chk("latency", 32'(k), 32'(e.lat));
                end
            end
            if (rst && bus.req_valid && bus.req_ready) begin
                act      = 1'b1;
                acc_a    = cyc;
                acc_wr   = bus.req_wr;
                acc_addr = bus.req_addr;
                acc_wd   = bus.req_wdata;
                n_acc++;
                acc_log.push_back(cyc);
                e.err   = (ardy_mode == 2);
                e.lat   = LAT + ext_cycles();
                e.rdata = e.err ? EBI_ERR_DATA :
                          acc_wr ? 16'h0000 : rd_pat(acc_addr);
                sb.push_back(e);
            end
            if (!rst) begin
                if (act && k < LAT) begin
                    void'(sb.pop_back());
                    n_acc--;
                end
                act = 1'b0;
            end
        end
        rst_prev_low = !rst;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic do_req(input logic wr, input logic [18:0] a,
                          input logic [15:0] d);
        int n0 = n_acc;
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (n_acc == n0 && t < 40) begin
            step();
            t++;
        end
        bus.req_valid = 1'b0;
        chk("accept", 32'(n_acc - n0), 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        int t = 0;
        while (n_rsp < target && t < 200) begin
            step();
            t++;
        end
        chk("rsp_wait", 32'(n_rsp >= target), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int t;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b0;
        step(3);
        mon_en = 1'b1;
        chk("rst_ctl",
            32'({bus.ebi_cs, bus.ebi_rd, bus.ebi_wr, bus.ebi_data_oe,
                 bus.rsp_valid, bus.req_ready, bus.rsp_err}), 32'(7'b1110000));
        chk("rst_addr", 32'(bus.ebi_addr), 32'd0);
        chk("rst_dout", 32'(bus.ebi_data_out), 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b1;
        step(2);

        do_req(1'b1, 19'h00012, 16'hBEEF);
        wait_rsp(1);
        step(2);

        do_req(1'b0, 19'h7FFFF, 16'h0000);
        wait_rsp(2);
        step(2);

        acc_log.delete();
        n0 = n_rsp;
        t = 0;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 19'h00400;
        while (acc_log.size() < 3 && t < 100) begin
            step();
            t++;
        end
        bus.req_valid = 1'b0;
        wait_rsp(n0 + 3);
        chk("b2b_gap1", 32'(acc_log[1] - acc_log[0]), 32'd9);
        chk("b2b_gap2", 32'(acc_log[2] - acc_log[1]), 32'd9);
        step(3);
        chk("b2b_rsps", 32'(n_rsp - n0), 32'd3);

        do_req(1'b0, 19'h00345, 16'h0000);
        step(3);
        rst = 1'b0;
        step();
        chk("abort_bus",
            32'({bus.ebi_cs, bus.ebi_rd, bus.ebi_wr, bus.ebi_data_oe,
                 bus.rsp_valid, bus.req_ready}), 32'(6'b111000));
        rst = 1'b1;
        n0 = n_rsp;
        step();
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        step(12);
        chk("abort_norsp", 32'(n_rsp), 32'(n0));
        do_req(1'b0, 19'h0ABCD, 16'h0000);
        wait_rsp(n0 + 1);
        step(2);

`ifdef EBI_ARDY_EN
        ardy_mode = 1;
        n0 = n_rsp;
        do_req(1'b0, 19'h00777, 16'h0000);
        wait_rsp(n0 + 1);
        step(3);
        ardy_mode = 2;
        do_req(1'b0, 19'h00888, 16'h0000);
        wait_rsp(n0 + 2);
        step(3);
        ardy_mode = 0;
        step(2);
`endif

        for (int i = 0; i < 10000; i++) begin
            bus.req_valid = ($urandom_range(0, 3) == 0);
            bus.req_wr    = 1'($urandom);
            bus.req_addr  = 19'($urandom);
            bus.req_wdata = 16'($urandom);
            rst = ($urandom_range(0, 499) != 0);
            step();
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        step(20);
        chk("acc_eq_rsp", 32'(n_rsp), 32'(n_acc));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
